pll_reset_sequencer: RTL

Sequences the main clock PLL from power-up to a usable state: pulses the PLL reset, waits for a stable lock, then releases the per-clock-domain resets one at a time. It also supervises lock for the rest of run time, re-runs the sequence on lock loss and declares a fault after repeated lock timeouts. It sits beside the main PLL wrapper, runs on the free-running board reference clock, and is the sole source of `rst` for the PLL and of reset for each of the eight PLL output domains.

---
 rtl/pll_reset_sequencer_if.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer (master) and its
// environment: PLL lock in, software restart in, PLL and domain resets out.
interface pll_reset_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 8,
    parameter int unsigned RELOCK_MAX  = 3
);
    localparam int unsigned RC_W = (RELOCK_MAX > 0) ? $clog2(RELOCK_MAX + 1) : 1;

    logic                   pll_locked;
    logic                   sw_reset;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst;
    logic                   ready;
    logic                   fault;
    logic [RC_W-1:0]        retry_count;

    modport master (
        input  pll_locked, sw_reset,
        output pll_rst, domain_rst, ready, fault, retry_count
    );

    modport slave (
        output pll_locked, sw_reset,
        input  pll_rst, domain_rst, ready, fault, retry_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL power-up/relock sequencer: pulses the PLL reset, qualifies a stable lock,
// releases the domain resets in staggered order and supervises lock afterwards.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned RELOCK_MAX   = 3,
    parameter int unsigned NUM_DOMAINS  = 8,
    parameter int unsigned STAGGER      = 4
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    localparam int unsigned RC_W       = (RELOCK_MAX > 0) ? $clog2(RELOCK_MAX + 1) : 1;
    localparam int unsigned RST_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned STB_W      = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int unsigned TO_W       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned STG_LAST_I = (NUM_DOMAINS - 1) * STAGGER;
    localparam int unsigned STG_W      = (STG_LAST_I > 0) ? $clog2(STG_LAST_I + 1) : 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(STG_LAST_I);
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(RELOCK_MAX);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t                 state, state_nxt;
    logic                   lock_meta, lock_s;
    logic [RST_W-1:0]       rst_cnt, rst_cnt_nxt;
    logic [STB_W-1:0]       stb_cnt, stb_cnt_nxt;
    logic [TO_W-1:0]        to_cnt, to_cnt_nxt;
    logic [STG_W-1:0]       stg_cnt, stg_cnt_nxt;
    logic [RC_W-1:0]        retry_q, retry_nxt;
    logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
    logic                   pll_rst_q, pll_rst_nxt;
    logic                   ready_q, ready_nxt;
    logic                   fault_q, fault_nxt;

    // State, counters, lock synchronizer and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= ST_RESET_PLL;
            rst_cnt   <= '0;
            stb_cnt   <= '0;
            to_cnt    <= '0;
            stg_cnt   <= '0;
            retry_q   <= '0;
            dom_q     <= '1;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            stb_cnt   <= stb_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            stg_cnt   <= stg_cnt_nxt;
            retry_q   <= retry_nxt;
            dom_q     <= dom_nxt;
            pll_rst_q <= pll_rst_nxt;
            ready_q   <= ready_nxt;
            fault_q   <= fault_nxt;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        stb_cnt_nxt = stb_cnt;
        to_cnt_nxt  = to_cnt;
        stg_cnt_nxt = stg_cnt;
        retry_nxt   = retry_q;
        dom_nxt     = dom_q;

        unique case (state)
            ST_RESET_PLL: begin
                if (rst_cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
                else                     rst_cnt_nxt = rst_cnt + 1'b1;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (to_cnt == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_nxt = retry_q + 1'b1;
                        state_nxt = ST_RESET_PLL;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                  state_nxt = ST_WAIT_LOCK;
                else if (stb_cnt == STB_LAST) state_nxt = ST_RELEASE;
                else                          stb_cnt_nxt = stb_cnt + 1'b1;
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_nxt = ST_RESET_PLL;
                    retry_nxt = '0;
                end else if (!dom_q[NUM_DOMAINS-1]) begin
                    state_nxt = ST_RUN;
                end else begin
                    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
                        if (stg_cnt == STG_W'(i * int'(STAGGER))) dom_nxt[i] = 1'b0;
                    end
                    if (stg_cnt != STG_LAST) stg_cnt_nxt = stg_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_RESET_PLL;
                    retry_nxt = '0;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_RESET_PLL;
            end
        endcase

        if (bus.sw_reset) begin
            state_nxt = ST_RESET_PLL;
            retry_nxt = '0;
        end

        // Every state entry (and any software restart) starts from zeroed counters
        if (bus.sw_reset || (state_nxt != state)) begin
            rst_cnt_nxt = '0;
            stb_cnt_nxt = '0;
            to_cnt_nxt  = '0;
            stg_cnt_nxt = '0;
        end

        if ((state_nxt != ST_RELEASE) && (state_nxt != ST_RUN)) dom_nxt = '1;

        pll_rst_nxt = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
        ready_nxt   = (state_nxt == ST_RUN);
        fault_nxt   = (state_nxt == ST_FAULT);
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.domain_rst  = dom_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
endmodule
